// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Two-master, one-slave round-robin arbiter for the 32-bit valid/ready memory
// bus (core + DMA/debug master -> single-port SRAM). One transaction is in
// flight at a time. A per-access watchdog forces completion of a hung slave
// access, returns ERR_RDATA and raises a sticky error flag.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   m{0,1}_valid/instr/addr/wdata/wstrb   master requests (held until ready)
//   m{0,1}_rdata/ready  read data and one-cycle completion pulse
//   s_valid/instr/addr/wdata/wstrb        request forwarded to the SRAM
//   s_rdata/s_ready     SRAM response
//   err_clear           clears timeout_err
//   timeout_err         sticky timeout flag
//   err_addr/err_master address and master of the first timeout since clear
module mem_bus_arbiter #(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    input  logic        err_clear,
    output logic        timeout_err,
    output logic [31:0] err_addr,
    output logic        err_master
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   err_addr_q, err_addr_d;
    logic          err_master_q, err_master_d;

    logic busy, timeout_hit, done;

    assign busy        = (state_q == BUSY);
    // s_ready on the last allowed cycle is a normal completion, not a timeout.
    assign timeout_hit = busy & ~s_ready & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign done        = busy & (s_ready | timeout_hit);

    // Slave side: forward the granted master only while BUSY, zeros in IDLE.
    assign s_valid = busy;
    assign s_instr = busy & (grant_q ? m1_instr : m0_instr);
    assign s_addr  = busy ? (grant_q ? m1_addr  : m0_addr)  : 32'h0;
    assign s_wdata = busy ? (grant_q ? m1_wdata : m0_wdata) : 32'h0;
    assign s_wstrb = busy ? (grant_q ? m1_wstrb : m0_wstrb) : 4'h0;

    // Master side
    assign m0_ready = done & ~grant_q;
    assign m1_ready = done &  grant_q;
    assign m0_rdata = m0_ready ? (timeout_hit ? ERR_RDATA : s_rdata) : 32'h0;
    assign m1_rdata = m1_ready ? (timeout_hit ? ERR_RDATA : s_rdata) : 32'h0;

    assign timeout_err = err_q;
    assign err_addr    = err_addr_q;
    assign err_master  = err_master_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        err_addr_d   = err_addr_q;
        err_master_d = err_master_q;

        case (state_q)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    grant_d = ~last_q;
                    state_d = BUSY;
                end else if (m0_valid) begin
                    grant_d = 1'b0;
                    state_d = BUSY;
                end else if (m1_valid) begin
                    grant_d = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    last_d  = grant_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A timeout beats a simultaneous clear; capture only the first
        // timeout since the last clear (a clear in the same cycle re-arms it).
        if (timeout_hit) begin
            err_d = 1'b1;
            if (!err_q || err_clear) begin
                err_addr_d   = s_addr;
                err_master_d = grant_q;
            end
        end else if (err_clear) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            err_addr_q   <= 32'h0;
            err_master_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            err_addr_q   <= err_addr_d;
            err_master_q <= err_master_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        s_valid, s_instr;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_ready, err_clear;
    logic        timeout_err, err_master;
    logic [31:0] err_addr;

    int n_cmp = 0;
    int n_bad = 0;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready),
        .err_clear(err_clear), .timeout_err(timeout_err),
        .err_addr(err_addr), .err_master(err_master)
    );

    always #5 clk = ~clk;

    // Inputs change right after the falling edge; outputs are sampled 1ns later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_m(input int m, input logic v, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] ws, input logic ins);
        if (m == 0) begin
            m0_valid = v; m0_addr = a; m0_wdata = wd; m0_wstrb = ws; m0_instr = ins;
        end else begin
            m1_valid = v; m1_addr = a; m1_wdata = wd; m1_wstrb = ws; m1_instr = ins;
        end
    endtask

    task automatic idle_inputs();
        drive_m(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive_m(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        s_ready = 1'b0; s_rdata = 32'h0; err_clear = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL reset_s_valid got %b exp 0", s_valid); end
        n_cmp++; if ({m0_ready, m1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b exp 00", {m0_ready, m1_ready}); end
        n_cmp++; if ({timeout_err, err_master, err_addr} !== 34'h0) begin n_bad++; $display("FAIL reset_err got %b/%b/%h exp 0/0/0", timeout_err, err_master, err_addr); end
        n_cmp++; if ({s_addr, s_wdata, s_wstrb, s_instr} !== 69'h0) begin n_bad++; $display("FAIL reset_s_bus got %h/%h/%h exp 0", s_addr, s_wdata, s_wstrb); end
    endtask

    task automatic test_single_read();
        step(); drive_m(0, 1'b1, 32'h100, 32'h0, 4'h0, 1'b1); #1;
        n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL rd_idle_s_valid got %b exp 0", s_valid); end
        step(); #1;
        n_cmp++; if (s_valid !== 1'b1 || s_addr !== 32'h100 || s_instr !== 1'b1) begin n_bad++; $display("FAIL rd_fwd got v=%b a=%h i=%b exp 1/100/1", s_valid, s_addr, s_instr); end
        n_cmp++; if (m0_ready !== 1'b0) begin n_bad++; $display("FAIL rd_early_ready got %b exp 0", m0_ready); end
        step(); s_ready = 1'b1; s_rdata = 32'h1234_5678; #1;
        n_cmp++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_done got r=%b d=%h exp 1/12345678", m0_ready, m0_rdata); end
        n_cmp++; if (m1_ready !== 1'b0 || m1_rdata !== 32'h0) begin n_bad++; $display("FAIL rd_other got r=%b d=%h exp 0/0", m1_ready, m1_rdata); end
        step(); idle_inputs(); #1;
        n_cmp++; if (m0_ready !== 1'b0 || s_valid !== 1'b0) begin n_bad++; $display("FAIL rd_after got r=%b v=%b exp 0/0", m0_ready, s_valid); end
    endtask

    task automatic test_alternation();
        logic [31:0] exp_addr;
        int          exp_m;
        do_reset();
        drive_m(0, 1'b1, 32'h1000, 32'h0, 4'h0, 1'b0);
        drive_m(1, 1'b1, 32'h2000, 32'h0, 4'h0, 1'b0);
        s_ready = 1'b1; s_rdata = 32'h5A5A_0000;
        for (int i = 0; i < 16; i++) begin
            step(); #1;
            if (i % 2 == 0) begin
                exp_m    = (i / 2) % 2;
                exp_addr = (exp_m == 0) ? 32'h1000 : 32'h2000;
                n_cmp++;
                if (s_valid !== 1'b1 || s_addr !== exp_addr || m0_ready !== (exp_m == 0) || m1_ready !== (exp_m == 1)) begin
                    n_bad++;
                    $display("FAIL alt_txn%0d got v=%b a=%h r0=%b r1=%b exp 1/%h master %0d", i / 2, s_valid, s_addr, m0_ready, m1_ready, exp_addr, exp_m);
                end
            end else begin
                n_cmp++;
                if (s_valid !== 1'b0) begin n_bad++; $display("FAIL alt_gap%0d got v=%b exp 0", i / 2, s_valid); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_fwd();
        step(); drive_m(1, 1'b1, 32'h204, 32'hCAFE_F00D, 4'b0011, 1'b0); #1;
        n_cmp++; if (s_wstrb !== 4'h0 || s_wdata !== 32'h0) begin n_bad++; $display("FAIL wr_idle got s=%h d=%h exp 0/0", s_wstrb, s_wdata); end
        step(); #1;
        n_cmp++; if (s_valid !== 1'b1 || s_addr !== 32'h204 || s_wdata !== 32'hCAFE_F00D || s_wstrb !== 4'b0011) begin n_bad++; $display("FAIL wr_fwd got a=%h d=%h s=%h exp 204/cafef00d/3", s_addr, s_wdata, s_wstrb); end
        step(); s_ready = 1'b1; #1;
        n_cmp++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin n_bad++; $display("FAIL wr_done got r1=%b r0=%b exp 1/0", m1_ready, m0_ready); end
        step(); idle_inputs(); #1;
        n_cmp++; if (s_wstrb !== 4'h0) begin n_bad++; $display("FAIL wr_after got s=%h exp 0", s_wstrb); end
    endtask

    // Runs a read that the slave never answers; optional err_clear on the hit cycle.
    task automatic run_timeout(input int m, input logic [31:0] a, input logic clr_on_hit);
        step(); drive_m(m, 1'b1, a, 32'h0, 4'h0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 4) err_clear = clr_on_hit;
            #1;
            if (c < 4) begin
                n_cmp++; if ((m == 0 ? m0_ready : m1_ready) !== 1'b0) begin n_bad++; $display("FAIL to_early_ready cyc%0d got 1 exp 0", c); end
            end else begin
                n_cmp++;
                if ((m == 0 ? m0_ready : m1_ready) !== 1'b1 || (m == 0 ? m0_rdata : m1_rdata) !== 32'hDEAD_BEEF) begin
                    n_bad++;
                    $display("FAIL to_hit got r=%b d=%h exp 1/deadbeef", (m == 0 ? m0_ready : m1_ready), (m == 0 ? m0_rdata : m1_rdata));
                end
            end
        end
        step(); idle_inputs();
    endtask

    task automatic test_timeout();
        run_timeout(1, 32'h300, 1'b0); #1;
        n_cmp++; if (timeout_err !== 1'b1 || err_addr !== 32'h300 || err_master !== 1'b1) begin n_bad++; $display("FAIL to_first got e=%b a=%h m=%b exp 1/300/1", timeout_err, err_addr, err_master); end
        run_timeout(0, 32'h400, 1'b0); #1;
        n_cmp++; if (timeout_err !== 1'b1 || err_addr !== 32'h300 || err_master !== 1'b1) begin n_bad++; $display("FAIL to_second got e=%b a=%h m=%b exp 1/300/1", timeout_err, err_addr, err_master); end
    endtask

    task automatic test_boundary();
        step(); err_clear = 1'b1;
        step(); err_clear = 1'b0; #1;
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL clr got %b exp 0", timeout_err); end
        drive_m(0, 1'b1, 32'h440, 32'h0, 4'h0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 4) begin s_ready = 1'b1; s_rdata = 32'hAAAA_5555; end
        end
        #1;
        n_cmp++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hAAAA_5555) begin n_bad++; $display("FAIL edge_done got r=%b d=%h exp 1/aaaa5555", m0_ready, m0_rdata); end
        step(); idle_inputs(); #1;
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL edge_noerr got %b exp 0", timeout_err); end
        run_timeout(1, 32'h500, 1'b0);
        run_timeout(0, 32'h600, 1'b1); #1;
        n_cmp++; if (timeout_err !== 1'b1 || err_addr !== 32'h600 || err_master !== 1'b0) begin n_bad++; $display("FAIL clr_vs_hit got e=%b a=%h m=%b exp 1/600/0", timeout_err, err_addr, err_master); end
    endtask

    task automatic test_reset_mid_busy();
        // Complete an m0 access so the round-robin pointer would favour m1.
        step(); drive_m(0, 1'b1, 32'h700, 32'h0, 4'h0, 1'b0);
        step(); s_ready = 1'b1;
        step(); idle_inputs();
        drive_m(1, 1'b1, 32'h800, 32'h0, 4'h0, 1'b0);
        step(); #1;
        n_cmp++; if (s_valid !== 1'b1 || s_addr !== 32'h800) begin n_bad++; $display("FAIL rst_pre got v=%b a=%h exp 1/800", s_valid, s_addr); end
        #1 rst = 1'b1; #1;
        n_cmp++; if (s_valid !== 1'b0 || m1_ready !== 1'b0 || m0_ready !== 1'b0 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_mid got v=%b r1=%b r0=%b e=%b exp 0/0/0/0", s_valid, m1_ready, m0_ready, timeout_err); end
        step(); idle_inputs();
        step(); rst = 1'b0;
        drive_m(0, 1'b1, 32'h900, 32'h0, 4'h0, 1'b0);
        drive_m(1, 1'b1, 32'hA00, 32'h0, 4'h0, 1'b0);
        step(); #1;
        n_cmp++; if (s_valid !== 1'b1 || s_addr !== 32'h900) begin n_bad++; $display("FAIL rst_tie got v=%b a=%h exp 1/900", s_valid, s_addr); end
        step(); idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_alternation();
        test_write_fwd();
        test_timeout();
        test_boundary();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
